// File: rtl/aes_enc_round_ctrl_if.sv
// ============================================================================
// aes_enc_round_ctrl_if : command/strobe bundle between round sequencer and AES datapath  (rev 1.0)
// ============================================================================
`default_nettype none

interface aes_enc_round_ctrl_if;
  logic       start;
  logic       state_loaded;
  logic       abort;
  logic       mix_done;
  logic [3:0] round_o;
  logic       sel_init;
  logic       ark_en;
  logic       sub_rd;
  logic [3:0] sub_rd_idx;
  logic       sub_wr;
  logic [3:0] sub_wr_idx;
  logic       shf_en;
  logic [1:0] shf_row;
  logic       mix_en;
  logic       busy;
  logic       done;

  modport master (
    input  start, state_loaded, abort, mix_done,
    output round_o, sel_init, ark_en, sub_rd, sub_rd_idx, sub_wr, sub_wr_idx,
           shf_en, shf_row, mix_en, busy, done
  );

  modport slave (
    output start, state_loaded, abort, mix_done,
    input  round_o, sel_init, ark_en, sub_rd, sub_rd_idx, sub_wr, sub_wr_idx,
           shf_en, shf_row, mix_en, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/aes_enc_round_ctrl.sv
// ============================================================================
// aes_enc_round_ctrl : single-FSM sequencer for the AES encryption rounds  (rev 1.0)
// ============================================================================
`default_nettype none

module aes_enc_round_ctrl #(
  parameter int ROUNDS   = 14,
  parameter int SBOX_LAT = 1,
  parameter int NBYTES   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  aes_enc_round_ctrl_if.master        bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARK  = 3'd1;
  localparam logic [2:0] S_SUB  = 3'd2;
  localparam logic [2:0] S_SHF  = 3'd3;
  localparam logic [2:0] S_MIX  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);
  localparam logic [4:0] WR_START   = 5'(SBOX_LAT);
  localparam logic [4:0] RD_COUNT   = 5'(NBYTES);
  localparam logic [3:0] LAST_IDX   = 4'(NBYTES - 1);

  logic [2:0] state;
  logic [2:0] state_next;
  logic [3:0] round_q;
  logic [3:0] round_next;
  logic [4:0] sub_cyc;
  logic [4:0] sub_cyc_next;
  logic [3:0] rd_idx;
  logic [3:0] rd_idx_next;
  logic [3:0] wr_idx;
  logic [3:0] wr_idx_next;
  logic [1:0] row;
  logic [1:0] row_next;
  logic       mix_wait;
  logic       mix_wait_next;

  logic       rd_act;
  logic       wr_act;
  logic       rd_act_next;
  logic       wr_act_next;

  logic       sel_d;
  logic       ark_d;
  logic       sub_rd_d;
  logic       sub_wr_d;
  logic       shf_d;
  logic       mix_d;
  logic       busy_d;
  logic       done_d;

  // Read and write byte pointers run on their own; the write side trails by the ROM latency.
  assign rd_act = (state == S_SUB) && (sub_cyc < RD_COUNT);
  assign wr_act = (state == S_SUB) && (sub_cyc >= WR_START);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (bus.start && bus.state_loaded) state_next = S_ARK;
      end
      S_ARK: begin
        state_next = (round_q == LAST_ROUND) ? S_DONE : S_SUB;
      end
      S_SUB: begin
        if (wr_act && (wr_idx == LAST_IDX)) state_next = S_SHF;
      end
      S_SHF: begin
        if (row == 2'd3) state_next = (round_q == LAST_ROUND) ? S_ARK : S_MIX;
      end
      S_MIX: begin
        if (mix_wait && bus.mix_done) state_next = S_ARK;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    // Cancel outranks every transition, including the completion step.
    if (bus.abort && (state != S_IDLE)) state_next = S_IDLE;
  end

  always_comb begin
    round_next = round_q;
    if (state_next == S_IDLE) begin
      round_next = 4'd0;
    end else if ((state == S_ARK) && (state_next == S_SUB)) begin
      round_next = round_q + 4'd1;
    end

    sub_cyc_next = ((state == S_SUB) && (state_next == S_SUB)) ? sub_cyc + 5'd1 : 5'd0;

    rd_idx_next = 4'd0;
    wr_idx_next = 4'd0;
    if (state_next == S_SUB) begin
      rd_idx_next = rd_act ? rd_idx + 4'd1 : rd_idx;
      wr_idx_next = wr_act ? wr_idx + 4'd1 : wr_idx;
    end

    row_next      = ((state == S_SHF) && (state_next == S_SHF)) ? row + 2'd1 : 2'd0;
    mix_wait_next = (state == S_MIX) && (state_next == S_MIX);

    rd_act_next = (state_next == S_SUB) && (sub_cyc_next < RD_COUNT);
    wr_act_next = (state_next == S_SUB) && (sub_cyc_next >= WR_START);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      round_q  <= 4'd0;
      sub_cyc  <= 5'd0;
      rd_idx   <= 4'd0;
      wr_idx   <= 4'd0;
      row      <= 2'd0;
      mix_wait <= 1'b0;
    end else begin
      round_q  <= round_next;
      sub_cyc  <= sub_cyc_next;
      rd_idx   <= rd_idx_next;
      wr_idx   <= wr_idx_next;
      row      <= row_next;
      mix_wait <= mix_wait_next;
    end
  end

  // Strobes are decoded from the upcoming state and flopped, so they are glitch-free Moore outputs.
  always_comb begin
    sel_d    = (round_next == 4'd0);
    ark_d    = (state_next == S_ARK);
    sub_rd_d = rd_act_next;
    sub_wr_d = wr_act_next;
    shf_d    = (state_next == S_SHF);
    mix_d    = (state_next == S_MIX) && !mix_wait_next;
    busy_d   = (state_next != S_IDLE);
    done_d   = (state_next == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.sel_init <= 1'b1;
      bus.ark_en   <= 1'b0;
      bus.sub_rd   <= 1'b0;
      bus.sub_wr   <= 1'b0;
      bus.shf_en   <= 1'b0;
      bus.mix_en   <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.sel_init <= sel_d;
      bus.ark_en   <= ark_d;
      bus.sub_rd   <= sub_rd_d;
      bus.sub_wr   <= sub_wr_d;
      bus.shf_en   <= shf_d;
      bus.mix_en   <= mix_d;
      bus.busy     <= busy_d;
      bus.done     <= done_d;
    end
  end

  assign bus.round_o    = round_q;
  assign bus.sub_rd_idx = rd_idx;
  assign bus.sub_wr_idx = wr_idx;
  assign bus.shf_row    = row;

endmodule

`default_nettype wire

// File: tb/tb_aes_enc_round_ctrl.sv
// ============================================================================
// tb_aes_enc_round_ctrl : directed bench for the AES round sequencer  (rev 1.0)
// ============================================================================
`default_nettype none

module tb_aes_enc_round_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  aes_enc_round_ctrl_if bus1 ();
  aes_enc_round_ctrl_if bus3 ();

  aes_enc_round_ctrl #(.ROUNDS(14), .SBOX_LAT(1), .NBYTES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  aes_enc_round_ctrl #(.ROUNDS(10), .SBOX_LAT(3), .NBYTES(16)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running exp finished");
    $fatal(1, "watchdog expired");
  end

  // {round, sel_init, ark_en, sub_rd, rd_idx, sub_wr, wr_idx, shf_en, shf_row, mix_en, busy, done}
  function automatic logic [21:0] pack(input logic [3:0] r, input logic sel, input logic ark,
                                       input logic rd, input logic [3:0] ri, input logic wr,
                                       input logic [3:0] wi, input logic shf, input logic [1:0] rw,
                                       input logic mix, input logic bsy, input logic dn);
    return {r, sel, ark, rd, ri, wr, wi, shf, rw, mix, bsy, dn};
  endfunction

  function automatic logic [21:0] v_idle();
    return pack(4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [21:0] v_ark(input logic [3:0] r);
    return pack(r, r == 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
  endfunction

  function automatic logic [21:0] v_sub(input logic [3:0] r, input logic rd, input logic [3:0] ri,
                                        input logic wr, input logic [3:0] wi);
    return pack(r, r == 4'd0, 1'b0, rd, ri, wr, wi, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
  endfunction

  function automatic logic [21:0] v_shf(input logic [3:0] r, input logic [1:0] rw);
    return pack(r, r == 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, rw, 1'b0, 1'b1, 1'b0);
  endfunction

  function automatic logic [21:0] v_mix(input logic [3:0] r, input logic en);
    return pack(r, r == 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 2'd0, en, 1'b1, 1'b0);
  endfunction

  function automatic logic [21:0] v_done(input logic [3:0] r);
    return pack(r, r == 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
  endfunction

  function automatic logic [21:0] snap1();
    return pack(bus1.round_o, bus1.sel_init, bus1.ark_en, bus1.sub_rd, bus1.sub_rd_idx, bus1.sub_wr,
                bus1.sub_wr_idx, bus1.shf_en, bus1.shf_row, bus1.mix_en, bus1.busy, bus1.done);
  endfunction

  function automatic logic [21:0] snap3();
    return pack(bus3.round_o, bus3.sel_init, bus3.ark_en, bus3.sub_rd, bus3.sub_rd_idx, bus3.sub_wr,
                bus3.sub_wr_idx, bus3.shf_en, bus3.shf_row, bus3.mix_en, bus3.busy, bus3.done);
  endfunction

  task automatic clear_inputs();
    bus1.start = 1'b0; bus1.state_loaded = 1'b0; bus1.abort = 1'b0; bus1.mix_done = 1'b0;
    bus3.start = 1'b0; bus3.state_loaded = 1'b0; bus3.abort = 1'b0; bus3.mix_done = 1'b0;
  endtask

  // Leaves the bench at posedge+1 of a fresh cycle with the FSMs idle.
  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (snap1() !== v_idle()) begin
      n_fail++; $display("FAIL reset_state_lat1: got %h exp %h", snap1(), v_idle());
    end
    n_checks++;
    if (snap3() !== v_idle()) begin
      n_fail++; $display("FAIL reset_state_lat3: got %h exp %h", snap3(), v_idle());
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_sub();
    logic found = 1'b0;
    do_reset();
    for (int t = 0; t <= 30; t++) begin
      bus1.start = (t == 0);
      bus1.state_loaded = 1'b1;
      @(negedge clk);
      if (bus1.sub_rd === 1'b1 && bus1.sub_rd_idx === 4'd7) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (found !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_sub_reach: got %b exp 1 (sub_rd_idx 7 never seen)", found);
    end
    // Asserted mid-cycle: the clear must be visible before any clock edge.
    reset = 1'b1;
    bus1.start = 1'b0;
    #1;
    n_checks++;
    if (snap1() !== v_idle()) begin
      n_fail++; $display("FAIL reset_mid_sub_async: got %h exp %h", snap1(), v_idle());
    end
    @(posedge clk);
    #1 reset = 1'b0;
    bus1.start = 1'b1;
    bus1.state_loaded = 1'b1;
    @(negedge clk);
    n_checks++;
    if (snap1() !== v_idle()) begin
      n_fail++; $display("FAIL reset_release_idle: got %h exp %h", snap1(), v_idle());
    end
    @(posedge clk);
    #1 bus1.start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (snap1() !== v_ark(4'd0)) begin
      n_fail++; $display("FAIL reset_release_ark: got %h exp %h", snap1(), v_ark(4'd0));
    end
  endtask

  task automatic test_full_block();
    logic [21:0] e;
    logic has_e;
    logic md = 1'b0;
    int n_ark = 0, n_mix = 0, n_rd = 0, n_wr = 0, n_shf = 0, n_done = 0, done_t = -1;
    do_reset();
    for (int t = 0; t <= 345; t++) begin
      bus1.start = (t == 0 || t == 100);
      bus1.state_loaded = 1'b1;
      bus1.mix_done = md;
      @(negedge clk);
      has_e = 1'b1;
      e = v_idle();
      case (t)
        0:       e = v_idle();
        1:       e = v_ark(4'd0);
        2:       e = v_sub(4'd1, 1'b1, 4'd0, 1'b0, 4'd0);
        3:       e = v_sub(4'd1, 1'b1, 4'd1, 1'b1, 4'd0);
        17:      e = v_sub(4'd1, 1'b1, 4'd15, 1'b1, 4'd14);
        18:      e = v_sub(4'd1, 1'b0, 4'd0, 1'b1, 4'd15);
        19:      e = v_shf(4'd1, 2'd0);
        22:      e = v_shf(4'd1, 2'd3);
        23:      e = v_mix(4'd1, 1'b1);
        24:      e = v_mix(4'd1, 1'b0);
        25:      e = v_ark(4'd1);
        26:      e = v_sub(4'd2, 1'b1, 4'd0, 1'b0, 4'd0);
        334:     e = v_shf(4'd14, 2'd3);
        335:     e = v_ark(4'd14);
        336:     e = v_done(4'd14);
        337:     e = v_idle();
        345:     e = v_idle();
        default: has_e = 1'b0;
      endcase
      if (has_e) begin
        n_checks++;
        if (snap1() !== e) begin
          n_fail++; $display("FAIL full_block t=%0d: got %h exp %h", t, snap1(), e);
        end
      end
      if (bus1.ark_en === 1'b1) n_ark++;
      if (bus1.mix_en === 1'b1) n_mix++;
      if (bus1.sub_rd === 1'b1) n_rd++;
      if (bus1.sub_wr === 1'b1) n_wr++;
      if (bus1.shf_en === 1'b1) n_shf++;
      if (bus1.done === 1'b1) begin n_done++; done_t = t; end
      md = bus1.mix_en;
      @(posedge clk);
      #1;
    end
    bus1.mix_done = 1'b0;
    n_checks++;
    if (n_ark !== 15) begin n_fail++; $display("FAIL full_ark_count: got %0d exp 15", n_ark); end
    n_checks++;
    if (n_mix !== 13) begin n_fail++; $display("FAIL full_mix_count: got %0d exp 13", n_mix); end
    n_checks++;
    if (n_rd !== 224) begin n_fail++; $display("FAIL full_sub_rd_count: got %0d exp 224", n_rd); end
    n_checks++;
    if (n_wr !== 224) begin n_fail++; $display("FAIL full_sub_wr_count: got %0d exp 224", n_wr); end
    n_checks++;
    if (n_shf !== 56) begin n_fail++; $display("FAIL full_shf_count: got %0d exp 56", n_shf); end
    n_checks++;
    if (n_done !== 1) begin n_fail++; $display("FAIL full_done_count: got %0d exp 1", n_done); end
    n_checks++;
    if (done_t !== 336) begin n_fail++; $display("FAIL full_done_cycle: got %0d exp 336", done_t); end
  endtask

  task automatic test_sbox_lat3();
    logic [21:0] e;
    logic has_e;
    logic md = 1'b0;
    int n_ark = 0, n_mix = 0, n_rd = 0, n_wr = 0, n_shf = 0, n_done = 0, done_t = -1;
    do_reset();
    for (int t = 0; t <= 265; t++) begin
      bus3.start = (t == 0);
      bus3.state_loaded = 1'b1;
      bus3.mix_done = md;
      @(negedge clk);
      has_e = 1'b1;
      e = v_idle();
      case (t)
        1:       e = v_ark(4'd0);
        2:       e = v_sub(4'd1, 1'b1, 4'd0, 1'b0, 4'd0);
        4:       e = v_sub(4'd1, 1'b1, 4'd2, 1'b0, 4'd0);
        5:       e = v_sub(4'd1, 1'b1, 4'd3, 1'b1, 4'd0);
        17:      e = v_sub(4'd1, 1'b1, 4'd15, 1'b1, 4'd12);
        18:      e = v_sub(4'd1, 1'b0, 4'd0, 1'b1, 4'd13);
        20:      e = v_sub(4'd1, 1'b0, 4'd0, 1'b1, 4'd15);
        21:      e = v_shf(4'd1, 2'd0);
        25:      e = v_mix(4'd1, 1'b1);
        27:      e = v_ark(4'd1);
        28:      e = v_sub(4'd2, 1'b1, 4'd0, 1'b0, 4'd0);
        258:     e = v_shf(4'd10, 2'd3);
        259:     e = v_ark(4'd10);
        260:     e = v_done(4'd10);
        261:     e = v_idle();
        default: has_e = 1'b0;
      endcase
      if (has_e) begin
        n_checks++;
        if (snap3() !== e) begin
          n_fail++; $display("FAIL sbox_lat3 t=%0d: got %h exp %h", t, snap3(), e);
        end
      end
      if (bus3.ark_en === 1'b1) n_ark++;
      if (bus3.mix_en === 1'b1) n_mix++;
      if (bus3.sub_rd === 1'b1) n_rd++;
      if (bus3.sub_wr === 1'b1) n_wr++;
      if (bus3.shf_en === 1'b1) n_shf++;
      if (bus3.done === 1'b1) begin n_done++; done_t = t; end
      md = bus3.mix_en;
      @(posedge clk);
      #1;
    end
    bus3.mix_done = 1'b0;
    n_checks++;
    if (n_ark !== 11) begin n_fail++; $display("FAIL lat3_ark_count: got %0d exp 11", n_ark); end
    n_checks++;
    if (n_mix !== 9) begin n_fail++; $display("FAIL lat3_mix_count: got %0d exp 9", n_mix); end
    n_checks++;
    if (n_rd !== 160) begin n_fail++; $display("FAIL lat3_sub_rd_count: got %0d exp 160", n_rd); end
    n_checks++;
    if (n_wr !== 160) begin n_fail++; $display("FAIL lat3_sub_wr_count: got %0d exp 160", n_wr); end
    n_checks++;
    if (n_shf !== 40) begin n_fail++; $display("FAIL lat3_shf_count: got %0d exp 40", n_shf); end
    n_checks++;
    if (n_done !== 1 || done_t !== 260) begin
      n_fail++; $display("FAIL lat3_done: got count %0d at t=%0d exp count 1 at t=260", n_done, done_t);
    end
  endtask

  task automatic test_start_drop();
    logic [21:0] e;
    do_reset();
    for (int t = 0; t <= 6; t++) begin
      bus1.start = (t == 0 || t == 5);
      bus1.state_loaded = (t != 0);
      @(negedge clk);
      e = (t == 6) ? v_ark(4'd0) : v_idle();
      n_checks++;
      if (snap1() !== e) begin
        n_fail++; $display("FAIL start_drop t=%0d: got %h exp %h", t, snap1(), e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mix_wait_abort();
    logic [21:0] e;
    logic has_e;
    int n_done = 0;
    do_reset();
    for (int t = 0; t <= 60; t++) begin
      bus1.start = (t == 0);
      bus1.state_loaded = 1'b1;
      bus1.mix_done = (t == 23 || t == 28 || t == 35);
      bus1.abort = (t == 53);
      @(negedge clk);
      has_e = 1'b1;
      e = v_idle();
      case (t)
        23:      e = v_mix(4'd1, 1'b1);
        24:      e = v_mix(4'd1, 1'b0);
        27:      e = v_mix(4'd1, 1'b0);
        28:      e = v_mix(4'd1, 1'b0);
        29:      e = v_ark(4'd1);
        30:      e = v_sub(4'd2, 1'b1, 4'd0, 1'b0, 4'd0);
        35:      e = v_sub(4'd2, 1'b1, 4'd5, 1'b1, 4'd4);
        47:      e = v_shf(4'd2, 2'd0);
        51:      e = v_mix(4'd2, 1'b1);
        53:      e = v_mix(4'd2, 1'b0);
        54:      e = v_idle();
        58:      e = v_idle();
        default: has_e = 1'b0;
      endcase
      if (has_e) begin
        n_checks++;
        if (snap1() !== e) begin
          n_fail++; $display("FAIL mix_wait_abort t=%0d: got %h exp %h", t, snap1(), e);
        end
      end
      if (bus1.done === 1'b1) n_done++;
      @(posedge clk);
      #1;
    end
    clear_inputs();
    n_checks++;
    if (n_done !== 0) begin n_fail++; $display("FAIL mix_abort_no_done: got %0d exp 0", n_done); end
  endtask

  task automatic test_abort_late(input int abort_t);
    logic [21:0] e;
    logic has_e;
    logic md = 1'b0;
    int n_done = 0;
    int exp_done;
    exp_done = (abort_t == 336) ? 1 : 0;
    do_reset();
    for (int t = 0; t <= 340; t++) begin
      bus1.start = (t == 0);
      bus1.state_loaded = 1'b1;
      bus1.abort = (t == 0 || t == abort_t);
      bus1.mix_done = md;
      @(negedge clk);
      has_e = 1'b1;
      e = v_idle();
      case (t)
        1:       e = v_ark(4'd0);
        335:     e = v_ark(4'd14);
        336:     e = (abort_t == 336) ? v_done(4'd14) : v_idle();
        337:     e = v_idle();
        default: has_e = 1'b0;
      endcase
      if (has_e) begin
        n_checks++;
        if (snap1() !== e) begin
          n_fail++; $display("FAIL abort_late(%0d) t=%0d: got %h exp %h", abort_t, t, snap1(), e);
        end
      end
      if (bus1.done === 1'b1) n_done++;
      md = bus1.mix_en;
      @(posedge clk);
      #1;
    end
    clear_inputs();
    n_checks++;
    if (n_done !== exp_done) begin
      n_fail++; $display("FAIL abort_late(%0d)_done_count: got %0d exp %0d", abort_t, n_done, exp_done);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_sub();
    test_full_block();
    test_sbox_lat3();
    test_start_drop();
    test_mix_wait_abort();
    test_abort_late(336);
    test_abort_late(335);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes_enc_round_ctrl.md
Name: aes_enc_round_ctrl

Overview:
Central sequencer for the AES-256 encryption datapath. It replaces the ad-hoc per-stage counters with one FSM. On a start command it schedules, cycle by cycle, the following steps: initial AddRoundKey, then per round byte-serial S-box substitution, row-serial ShiftRows, MixColumns (skipped in the final round) and AddRoundKey. It drives round/key selection, stage strobes and completion status.

Parameters:
ROUNDS, 14, number of AES rounds (10/12/14 legal).
SBOX_LAT, 1, S-box ROM read latency in cycles (0..3).
NBYTES, 16, state bytes per block (fixed; not overridable in practice).

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request (control register bit 0 write)
state_loaded  in  1  input state register holds a full 128-bit block
abort  in  1  synchronous cancel of the current block
mix_done  in  1  MixColumns result valid
round_o  out  4  current round; drives key ROM select and input mux select
sel_init  out  1  high when round_o==0 (addRK takes input-block path)
ark_en  out  1  one-cycle AddRoundKey capture strobe
sub_rd  out  1  read one byte from the 16-to-1 register toward the S-box
sub_rd_idx  out  4  byte index being read
sub_wr  out  1  write S-box output into the 1-to-16 register
sub_wr_idx  out  4  byte index being written
shf_en  out  1  ShiftRows row strobe
shf_row  out  2  row being shifted
mix_en  out  1  one-cycle MixColumns start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle block-complete pulse; also clears the control register

Behaviour:
- Reset (async, any state): state=IDLE. round_o=0 and sel_init=1. All other outputs 0. All counters 0.
- IDLE: if start && state_loaded, go to ARK with round_o=0. start with state_loaded=0 is dropped and not remembered.
- ARK (1 cycle):
  - ark_en=1.
  - If round_o==ROUNDS, go to DONE.
  - Otherwise round_o increments and the FSM goes to SUB.
- SUB (16+SBOX_LAT cycles):
  - sub_rd=1 on cycles 0..15 with sub_rd_idx=0..15.
  - sub_wr=1 on cycles SBOX_LAT..SBOX_LAT+15 with sub_wr_idx=0..15.
  - Read and write counters are independent 4-bit counters, so they overlap.
  - Exit to SHF on the cycle sub_wr_idx==15 is written.
- SHF (4 cycles): shf_en=1 with shf_row=0,1,2,3. After row 3:
  - if round_o==ROUNDS, go to ARK (MixColumns bypassed);
  - otherwise go to MIX.
- MIX:
  - mix_en=1 on the first MIX cycle only.
  - mix_done is ignored in that cycle; it is sampled from the next cycle on.
  - On mix_done=1, go to ARK. The FSM waits indefinitely; there is no timeout.
- DONE (1 cycle): done=1, busy=1, then go to IDLE. round_o holds ROUNDS until IDLE, then clears to 0.
- mix_done outside MIX is ignored. start outside IDLE is ignored: no queueing, no restart.
- abort in any non-IDLE state:
  - next cycle state=IDLE and round_o=0;
  - all strobes drop that same next cycle;
  - done is not pulsed.
  - abort in IDLE has no effect.
  - abort has priority over every transition, including DONE.
- Strobes are registered (Moore outputs); no output depends combinationally on an input.
- The round counter is 4 bits wide; ROUNDS≤14, so it never wraps.
- Latency (SBOX_LAT=1, mix_done one cycle after mix_en, start at cycle 0):
  - ARK at cycle 1;
  - each round 1..ROUNDS-1 takes 17+4+2+1=24 cycles;
  - the final round takes 17+4+1=22 cycles;
  - for ROUNDS=14, done=1 at cycle 336.

Test Plan:
- Reset mid-SUB at sub_rd_idx=7 -> same cycle round_o=0, busy=0, sub_rd=0, sel_init=1. After release, start+state_loaded gives ark_en at the next cycle.
- Full block, ROUNDS=14, SBOX_LAT=1, mix_done one cycle after mix_en -> ark_en pulses 15 times and mix_en 13 times. sub_rd and sub_wr each pulse 16×14=224 times. shf_en pulses 56 times. done=1 only at cycle 336.
- Final round -> after shf_row=3 with round_o=14, no mix_en; the next cycle has ark_en=1 with round_o=14, followed by done.
- SBOX_LAT=3 -> in SUB, sub_wr first rises 3 cycles after sub_rd. SUB lasts 19 cycles, and sub_wr_idx=15 occurs 3 cycles after sub_rd_idx=15.
- start with state_loaded=0, then state_loaded=1 without start -> the FSM stays IDLE. A start pulse during busy causes no second run (exactly one done).
- abort asserted during MIX, and separately in the DONE cycle -> next cycle IDLE and round_o=0. No done pulse in the MIX case. In the DONE case done is suppressed only if abort is sampled before the DONE cycle; an abort coinciding with DONE still yields done=1 that cycle.
